// File: rtl/fifo_rd_ptr_sync_pkg.sv
// fifo_rd_ptr_sync_pkg
// Shared constants and helpers for the AudioNet clock-crossing sample FIFO
// pointer controllers (read side here, write side elsewhere).
//   DEF_ADDR_W : default FIFO address width (depth = 2**DEF_ADDR_W)
//   DEF_PTR_W  : default pointer width, one extra wrap bit
//   bin2gc()   : binary to Grey conversion, width-agnostic up to 32 bits
package fifo_rd_ptr_sync_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_PTR_W  = DEF_ADDR_W + 1;

   // Operates on a zero-extended 32-bit value; callers truncate to their
   // pointer width. Upper zero bits leave the low Grey bits unaffected.
   function automatic logic [31:0] bin2gc(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/fifo_rd_ptr_sync_if.sv
// fifo_rd_ptr_sync_if
// Read-side FIFO pointer bundle between the read controller and its
// surroundings (write-pointer source, RAM, consumer).
//   wr_ptr_gc : Grey write pointer from the write clock domain
//   rd_en     : read request
//   rd_addr   : RAM read address
//   rd_ptr_gc : registered Grey read pointer back to the write side
//   rd_valid  : RAM read data valid
//   empty     : FIFO empty (registered)
//   level     : fill count 0..2**ADDR_W (registered)
//   underflow : sticky read-while-empty flag, only when
//               FIFO_UNDERFLOW_FLAG_EN is defined
// Modports: slave = the read controller, master = its environment.
interface fifo_rd_ptr_sync_if
   import fifo_rd_ptr_sync_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);
   localparam int PTR_W = ADDR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_gc;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [PTR_W-1:0]  rd_ptr_gc;
   logic              rd_valid;
   logic              empty;
   logic [PTR_W-1:0]  level;
`ifdef FIFO_UNDERFLOW_FLAG_EN
   logic              underflow;
`endif

`ifdef FIFO_UNDERFLOW_FLAG_EN
   modport slave (
      input  wr_ptr_gc, rd_en,
      output rd_addr, rd_ptr_gc, rd_valid, empty, level, underflow
   );
   modport master (
      output wr_ptr_gc, rd_en,
      input  rd_addr, rd_ptr_gc, rd_valid, empty, level, underflow
   );
`else
   modport slave (
      input  wr_ptr_gc, rd_en,
      output rd_addr, rd_ptr_gc, rd_valid, empty, level
   );
   modport master (
      output wr_ptr_gc, rd_en,
      input  rd_addr, rd_ptr_gc, rd_valid, empty, level
   );
`endif

endinterface

// File: rtl/fifo_rd_ptr_sync_gc2bin.sv
// gc2bin
// Combinational Grey to binary decoder.
//   gc  : Grey-coded input, WIDTH bits
//   bin : binary output, WIDTH bits
// Each binary bit is the XOR of all Grey bits at and above its position.
module gc2bin #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gc,
   output logic [WIDTH-1:0] bin
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
         assign bin[gi] = ^gc[WIDTH-1:gi];
      end
   endgenerate

endmodule

// File: rtl/fifo_rd_ptr_sync.sv
// fifo_rd_ptr_sync
// Read-side pointer and flag controller for the AudioNet clock-crossing
// sample FIFO. Synchronises the Grey write pointer through two flops,
// decodes it to binary, keeps the binary/Grey read pointer and produces
// the RAM read address, empty, fill level and read-data-valid strobe.
//   clk : read-domain clock
//   rst : synchronous active-high reset
//   bus : fifo_rd_ptr_sync_if.slave (wr_ptr_gc, rd_en in;
//         rd_addr, rd_ptr_gc, rd_valid, empty, level out)
// Optional: define FIFO_UNDERFLOW_FLAG_EN to add the sticky bus.underflow
// output, set after any cycle with rd_en while empty, cleared by rst.
module fifo_rd_ptr_sync
   import fifo_rd_ptr_sync_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   fifo_rd_ptr_sync_if.slave   bus
);
   localparam int PTR_W = ADDR_W + 1;

   logic [PTR_W-1:0] sync_s1_reg;
   logic [PTR_W-1:0] sync_s2_reg;
   logic [PTR_W-1:0] wr_bin;
   logic [PTR_W-1:0] rd_bin_reg;
   logic [PTR_W-1:0] rd_bin_next;
   logic [PTR_W-1:0] rd_gc_reg;
   logic [PTR_W-1:0] rd_gc_next;
   logic             rd_valid_reg;
   logic             empty_reg;
   logic [PTR_W-1:0] level_reg;
   logic [PTR_W-1:0] level_next;
   logic             empty_next;
   logic             acc;

   // Only the second sync stage is decoded; s1 may be metastable.
   gc2bin #(.WIDTH(PTR_W)) u_gc2bin (
      .gc  (sync_s2_reg),
      .bin (wr_bin)
   );

   // empty is registered and asserts the cycle after the last accept, so
   // gating with it never lets a read run past the write pointer.
   assign acc         = bus.rd_en & ~empty_reg;
   assign rd_bin_next = rd_bin_reg + PTR_W'(acc);
   assign rd_gc_next  = PTR_W'(bin2gc(32'(rd_bin_next)));
   // Modulo subtraction; the extra wrap bit lets level reach 2**ADDR_W.
   assign level_next  = wr_bin - rd_bin_next;
   assign empty_next  = (wr_bin == rd_bin_next);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_s1_reg  <= '0;
         sync_s2_reg  <= '0;
         rd_bin_reg   <= '0;
         rd_gc_reg    <= '0;
         rd_valid_reg <= 1'b0;
         empty_reg    <= 1'b1;
         level_reg    <= '0;
      end else begin
         sync_s1_reg  <= bus.wr_ptr_gc;
         sync_s2_reg  <= sync_s1_reg;
         rd_bin_reg   <= rd_bin_next;
         rd_gc_reg    <= rd_gc_next;
         rd_valid_reg <= acc;
         empty_reg    <= empty_next;
         level_reg    <= level_next;
      end
   end

   assign bus.rd_addr   = rd_bin_reg[ADDR_W-1:0];
   assign bus.rd_ptr_gc = rd_gc_reg;
   assign bus.rd_valid  = rd_valid_reg;
   assign bus.empty     = empty_reg;
   assign bus.level     = level_reg;

`ifdef FIFO_UNDERFLOW_FLAG_EN
   logic underflow_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         underflow_reg <= 1'b0;
      end else if (bus.rd_en & empty_reg) begin
         underflow_reg <= 1'b1;
      end
   end

   assign bus.underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_ptr_sync.sv
// tb_fifo_rd_ptr_sync
// Directed bench for fifo_rd_ptr_sync with ADDR_W=4. Inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_fifo_rd_ptr_sync;
   import fifo_rd_ptr_sync_pkg::*;

   localparam int ADDR_W = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   fifo_rd_ptr_sync_if #(.ADDR_W(ADDR_W)) bus ();

   fifo_rd_ptr_sync #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, exp_v);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.wr_ptr_gc = '0;
      bus.rd_en     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [4:0] first_gc [3];

   initial begin
      checks   = 0;
      failures = 0;
      first_gc[0] = 5'b00001;
      first_gc[1] = 5'b00011;
      first_gc[2] = 5'b00010;

      // Reset state
      do_reset();
      check("rst_empty",    32'(bus.empty),     32'd1);
      check("rst_level",    32'(bus.level),     32'd0);
      check("rst_rd_ptr",   32'(bus.rd_ptr_gc), 32'd0);
      check("rst_rd_valid", 32'(bus.rd_valid),  32'd0);
      check("rst_rd_addr",  32'(bus.rd_addr),   32'd0);

      // Fill to 3: Grey(3)=00010, empty falls on the third edge
      bus.wr_ptr_gc = 5'b00010;
      tick();
      tick();
      check("fill_empty_e2", 32'(bus.empty), 32'd1);
      tick();
      check("fill_empty_e3", 32'(bus.empty), 32'd0);
      check("fill_level",    32'(bus.level), 32'd3);

      // Three back-to-back reads
      bus.rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rd%0d_addr", i), 32'(bus.rd_addr), 32'(i));
         tick();
         check($sformatf("rd%0d_valid", i), 32'(bus.rd_valid), 32'd1);
         check($sformatf("rd%0d_gc", i), 32'(bus.rd_ptr_gc), 32'(first_gc[i]));
         check($sformatf("rd%0d_level", i), 32'(bus.level), 32'(2 - i));
      end
      check("drain_empty", 32'(bus.empty), 32'd1);

      // Underflow: rd_en held while empty
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("uf%0d_addr", i),  32'(bus.rd_addr),  32'd3);
         check($sformatf("uf%0d_valid", i), 32'(bus.rd_valid), 32'd0);
`ifdef FIFO_UNDERFLOW_FLAG_EN
         check($sformatf("uf%0d_flag", i), 32'(bus.underflow), 32'd1);
`endif
      end
      bus.rd_en = 1'b0;
      tick();
`ifdef FIFO_UNDERFLOW_FLAG_EN
      check("uf_sticky", 32'(bus.underflow), 32'd1);
`endif

      // Mid-operation reset discards pointer state
      do_reset();
      check("rst2_empty",   32'(bus.empty),     32'd1);
      check("rst2_rd_addr", 32'(bus.rd_addr),   32'd0);
      check("rst2_rd_ptr",  32'(bus.rd_ptr_gc), 32'd0);
`ifdef FIFO_UNDERFLOW_FLAG_EN
      check("rst2_uf", 32'(bus.underflow), 32'd0);
`endif

      // Full level: Grey(16)=11000 with rd_bin=0
      bus.wr_ptr_gc = 5'b11000;
      tick();
      tick();
      check("full_empty_e2", 32'(bus.empty), 32'd1);
      tick();
      check("full_level", 32'(bus.level), 32'd16);
      check("full_empty", 32'(bus.empty), 32'd0);

      // Drain 16 entries: read pointer wraps to 10000
      bus.rd_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check($sformatf("wrap%0d_addr", k), 32'(bus.rd_addr), 32'(k));
         tick();
         check($sformatf("wrap%0d_level", k), 32'(bus.level), 32'(15 - k));
         check($sformatf("wrap%0d_valid", k), 32'(bus.rd_valid), 32'd1);
      end
      bus.rd_en = 1'b0;
      check("wrap_rd_addr", 32'(bus.rd_addr),   32'd0);
      check("wrap_rd_ptr",  32'(bus.rd_ptr_gc), 32'b11000);
      check("wrap_empty",   32'(bus.empty),     32'd1);
      tick();
      check("wrap_valid_off", 32'(bus.rd_valid), 32'd0);

      // Simultaneous: write at 20 (Grey 11110), level 4, then write 20->21
      // (Grey 11111) on the same edge a read is accepted.
      bus.wr_ptr_gc = 5'b11110;
      tick();
      tick();
      tick();
      check("sim_pre_level", 32'(bus.level), 32'd4);
      check("sim_pre_empty", 32'(bus.empty), 32'd0);
      bus.wr_ptr_gc = 5'b11111;
      bus.rd_en     = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      check("sim_e1_valid", 32'(bus.rd_valid),  32'd1);
      check("sim_e1_level", 32'(bus.level),     32'd3);
      check("sim_e1_empty", 32'(bus.empty),     32'd0);
      check("sim_e1_rd_gc", 32'(bus.rd_ptr_gc), 32'b11001);
      tick();
      check("sim_e2_valid", 32'(bus.rd_valid), 32'd0);
      check("sim_e2_level", 32'(bus.level),    32'd3);
      check("sim_e2_empty", 32'(bus.empty),    32'd0);
      tick();
      check("sim_e3_level", 32'(bus.level),    32'd4);
      check("sim_e3_empty", 32'(bus.empty),    32'd0);
      check("sim_e3_valid", 32'(bus.rd_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
